uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVS, default 16: rxen ticks per bit period; legal range 4..16.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 rxd  input  1  serial line, idle high; asynchronous to clk.
REQ-005 rxen  input  1  oversample tick, one clk cycle wide, OVS ticks per bit.
REQ-006 rx_data  output  8  last received byte; LSB received first.
REQ-007 rx_valid  output  1  one-clk pulse when rx_data/flags update.
REQ-008 frame_err  output  1  stop bit of the frame in rx_data sampled low.
REQ-009 parity_err  output  1  parity mismatch of the frame in rx_data; present only with UART_RX_PARITY_EN.

Function
REQ-010 rxd SHALL pass a 2-flop synchronizer; the FSM uses only the synchronized rxd_s (2-clk input latency).
REQ-011 Tick counter tcnt (0..OVS-1) and bit counter bcnt (0..7) SHALL advance only on cycles with rxen=1; all state otherwise holds.
REQ-012 States: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE -> START on a rxen tick with rxd_s=0; tcnt cleared to 0.
REQ-014 START: at tcnt=OVS/2-1 (mid-bit), rxd_s=0 -> DATA with tcnt=0, bcnt=0; rxd_s=1 -> IDLE (glitch rejected, no outputs change).
REQ-015 DATA: at tcnt=OVS-1, rxd_s shifts into shift register MSB position (right shift), tcnt wraps to 0; after bcnt=7 sample -> PARITY if enabled, else STOP.
REQ-016 PARITY: at tcnt=OVS-1, sample parity bit; mismatch vs even parity of the 8 data bits latched internally -> STOP.
REQ-017 STOP: at tcnt=OVS-1, on the same clk: rx_data <= shift register, frame_err <= ~rxd_s, parity_err <= latched mismatch, rx_valid=1 for exactly that cycle; next state IDLE.
REQ-018 rx_data, frame_err, parity_err SHALL hold until the next rx_valid; a frame with frame_err still updates rx_data.
REQ-019 IDLE after a frame error with rxd_s still low SHALL start a new frame on the next tick (no break detection).
REQ-020 Frame-to-frame: a start edge on the first tick after STOP SHALL be accepted (no lost back-to-back frames).
REQ-021 Illegal state encoding SHALL return to IDLE on the next clk.

Reset
REQ-022 n_rst low: state IDLE, tcnt=0, bcnt=0, shift register 0x00, rx_data=0x00, rx_valid=0, frame_err=0, parity_err=0, synchronizer flops=1.
REQ-023 Reset mid-frame SHALL discard the partial byte; no rx_valid is produced for it.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state, even-parity bit between data and stop, parity_err port present; frame length 11 bits.
REQ-025 Macro undefined: no PARITY state, no parity_err port, frame length 10 bits (1 start, 8 data, 1 stop).

Structure
REQ-026 Shared package uart_pkg SHALL hold the state encodings, data width (8), and the default OVS; the transmitter shares it.
REQ-027 Synchronizer SHALL be the sub-module uart_sync2 (2-flop, reset value 1); all else in uart_rx.

Verification (OVS=16, rxen every clk unless stated)
REQ-028 Frame 0xA5 with valid stop -> one rx_valid pulse, rx_data=0xA5, frame_err=0, pulse 2 clk + ~9.5 bit periods after the start edge.
REQ-029 rxd low for 4 ticks then high -> back to IDLE, no rx_valid, rx_data unchanged.
REQ-030 Frame 0x3C with stop bit low -> rx_valid, rx_data=0x3C, frame_err=1; next good frame 0x55 -> frame_err=0.
REQ-031 Back-to-back 0x00 then 0xFF, zero idle gap -> two rx_valid pulses, rx_data 0x00 then 0xFF.
REQ-032 n_rst pulsed during bit 4 of frame 0x81, then frame 0x7E -> no pulse for 0x81, one pulse rx_data=0x7E.
REQ-033 UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1; rxen every 3rd clk -> same results at 3x timing.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, data width and default oversampling shared by the UART receiver and transmitter.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
  localparam int DATA_W  = 8;
  localparam int OVS_DEF = 16;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for the idle-high serial line.
module uart_sync2 (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) {q, meta} <= 2'b11;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, OVS rxen ticks per bit, LSB first.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS = OVS_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rxd,
  input  logic              rxen,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  logic              rxd_s;
  state_t            state, state_n;
  logic [3:0]        tcnt, tcnt_n;
  logic [2:0]        bcnt, bcnt_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              bit_end, mid, done;

  uart_sync2 u_sync (.clk(clk), .n_rst(n_rst), .d(rxd), .q(rxd_s));

  assign bit_end = rxen && tcnt == 4'(OVS - 1);
  assign mid     = rxen && tcnt == 4'(OVS / 2 - 1);

  always_comb begin
    state_n = state;
    tcnt_n  = rxen ? tcnt + 4'd1 : tcnt;
    bcnt_n  = bcnt;
    shift_n = shift;
    done    = 1'b0;
    case (state)
      IDLE: begin
        tcnt_n  = '0;
        state_n = (rxen && !rxd_s) ? START : IDLE;
      end
      START: if (mid) begin
        tcnt_n  = '0;
        bcnt_n  = '0;
        state_n = rxd_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        tcnt_n  = '0;
        shift_n = {rxd_s, shift[DATA_W-1:1]};
        bcnt_n  = bcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
        state_n = (bcnt == 3'd7) ? PARITY : DATA;
`else
        state_n = (bcnt == 3'd7) ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) begin
        tcnt_n  = '0;
        state_n = STOP;
      end
`endif
      STOP: if (bit_end) begin
        tcnt_n  = '0;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        tcnt_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state    <= state_n;
      tcnt     <= tcnt_n;
      bcnt     <= bcnt_n;
      shift    <= shift_n;
      rx_valid <= done;
      if (done) begin
        rx_data   <= shift;
        frame_err <= ~rxd_s;
      end
    end

`ifdef UART_RX_PARITY_EN
  // Mismatch is latched at the parity sample and published with the stop bit.
  logic perr;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      perr       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && bit_end) perr <= ^{shift, rxd_s};
      if (done) parity_err <= perr;
    end
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (OVS=16); parity cases need UART_RX_PARITY_EN.
module tb_uart_rx;
  localparam int OVS = 16;
  logic       clk = 1'b0, n_rst = 1'b0, rxd = 1'b1, rxen = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif
  int ncmp = 0, nfail = 0, cyc = 0, dv = 1, phase = 0, npulse = 0, pulse_cyc = 0, c0 = 0, lat = 0;
  logic [7:0] rx_log[$];

  uart_rx #(.OVS(OVS)) dut (
    .clk(clk), .n_rst(n_rst), .rxd(rxd), .rxen(rxen),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rx_valid) begin
      npulse++;
      pulse_cyc = cyc;
      rx_log.push_back(rx_data);
    end

  task automatic step();
    @(posedge clk);
    #1;
    phase = (phase + 1 >= dv) ? 0 : phase + 1;
    rxen  = (phase == 0);
    cyc++;
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold(1'b0, OVS * dv);
    for (int i = 0; i < 8; i++) hold(d[i], OVS * dv);
`ifdef UART_RX_PARITY_EN
    hold(^d ^ par_flip, OVS * dv);
`endif
    hold(stop, OVS * dv);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    repeat (3) step();
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
`ifdef UART_RX_PARITY_EN
    check("reset_parity_err", parity_err, 1'b0);
`endif
    n_rst = 1'b1;
    hold(1'b1, 32);

    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 16);
    check("a5_pulses", npulse, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_frame_err", frame_err, 1'b0);
    lat = pulse_cyc - c0;
    ncmp++;
    assert (lat >= 151 && lat <= 157) else begin
      nfail++;
      $error("FAIL a5_latency: observed %0d cycles expected 151..157", lat);
    end

    hold(1'b0, 4);
    hold(1'b1, 64);
    check("glitch_pulses", npulse, 1);
    check("glitch_data", rx_data, 8'hA5);

    send_frame(8'h3C, 1'b0);
    hold(1'b1, 48);
    check("3c_pulses", npulse, 2);
    check("3c_data", rx_data, 8'h3C);
    check("3c_frame_err", frame_err, 1'b1);

    send_frame(8'h55, 1'b1);
    hold(1'b1, 16);
    check("55_pulses", npulse, 3);
    check("55_data", rx_data, 8'h55);
    check("55_frame_err", frame_err, 1'b0);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 16);
    check("b2b_pulses", npulse, 5);
    check("b2b_first", rx_log[3], 8'h00);
    check("b2b_second", rx_log[4], 8'hFF);

    hold(1'b0, OVS);
    for (int i = 0; i < 4; i++) hold(i == 0, OVS);
    hold(1'b0, OVS / 2);
    n_rst = 1'b0;
    step();
    check("midreset_rx_data", rx_data, 8'h00);
    n_rst = 1'b1;
    hold(1'b1, 3 * OVS);
    check("midreset_pulses", npulse, 5);
    send_frame(8'h7E, 1'b1);
    hold(1'b1, 16);
    check("7e_pulses", npulse, 6);
    check("7e_data", rx_data, 8'h7E);

`ifdef UART_RX_PARITY_EN
    for (int k = 1; k <= 3; k += 2) begin
      dv = k;
      phase = 0;
      par_flip = 1'b0;
      send_frame(8'h07, 1'b1);
      hold(1'b1, 16 * dv);
      check("par_good_data", rx_data, 8'h07);
      check("par_good_err", parity_err, 1'b0);
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      hold(1'b1, 16 * dv);
      check("par_bad_err", parity_err, 1'b1);
      check("par_bad_frame_err", frame_err, 1'b0);
    end
    check("par_pulses", npulse, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
